// File: rtl/mult_pkg.sv
// Shared definitions for the shift-and-add multiplier slice.
// Provides the default operand width and the controller state encoding.
// Encoding 2'd3 is unused; the controller steers it back to IDLE.
package mult_pkg;

    localparam int DEFAULT_WIDTH = 8;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        CALC = ST_CALC,
        DONE = ST_DONE
    } state_e;

endpackage

// File: rtl/mult_datapath.sv
// Datapath of the sequential unsigned shift-and-add multiplier.
// Holds the multiplicand and the {carry, upper, lower} accumulator.
// Ports:
//   clk, reset  - rising-edge clock, asynchronous active-high reset
//   load_i      - capture a_i into mcand and {0, 0, b_i} into acc
//   step_i      - one conditional-add and right-shift iteration
//   a_i, b_i    - multiplicand / multiplier operands
//   product_o   - lower 2*WIDTH bits of the accumulator, always driven
module mult_datapath
    import mult_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load_i,
    input  logic               step_i,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    output logic [2*WIDTH-1:0] product_o
);

    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [2*WIDTH:0] acc_q, acc_d;
    logic [WIDTH:0]   sum;

    // The multiplier bits sit in the low half of acc and are consumed from
    // bit 0 as the partial product shifts in from above. The extra top bit
    // keeps the adder carry so the upper half never overflows.
    always_comb begin
        mcand_d = mcand_q;
        acc_d   = acc_q;
        sum     = acc_q[2*WIDTH:WIDTH] + (acc_q[0] ? {1'b0, mcand_q} : '0);
        if (load_i) begin
            mcand_d = a_i;
            acc_d   = {1'b0, {WIDTH{1'b0}}, b_i};
        end else if (step_i) begin
            acc_d = {sum, acc_q[WIDTH-1:0]} >> 1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mcand_q <= '0;
            acc_q   <= '0;
        end else begin
            mcand_q <= mcand_d;
            acc_q   <= acc_d;
        end
    end

    assign product_o = acc_q[2*WIDTH-1:0];

endmodule

// File: rtl/shift_add_mult_ctrl.sv
// Sequential unsigned shift-and-add multiplier: controller plus datapath.
// One add/shift iteration per cycle; WIDTH iterations per product.
// Ports:
//   clk, reset  - rising-edge clock, asynchronous active-high reset
//   start_i     - request, honoured only in IDLE or DONE
//   a_i, b_i    - operands, captured on the accepting edge
//   busy_o      - high while iterating (CALC)
//   done_o      - one-cycle pulse, product_o valid
//   product_o   - 2*WIDTH-bit result, held until the next accepted start
module shift_add_mult_ctrl
    import mult_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start_i,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    output logic               busy_o,
    output logic               done_o,
    output logic [2*WIDTH-1:0] product_o
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             load;
    logic             step;

    // Next-state and enables. DONE behaves like IDLE for start so a held
    // start chains operations back-to-back; start during CALC is ignored.
    // The unused encoding falls through to default and returns to IDLE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        load    = 1'b0;
        step    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    load    = 1'b1;
                    cnt_d   = '0;
                    state_d = CALC;
                end
            end
            CALC: begin
                step  = 1'b1;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_CNT) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (start_i) begin
                    load    = 1'b1;
                    cnt_d   = '0;
                    state_d = CALC;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy_o = (state_q == CALC);
    assign done_o = (state_q == DONE);

    mult_datapath #(
        .WIDTH(WIDTH)
    ) u_datapath (
        .clk      (clk),
        .reset    (reset),
        .load_i   (load),
        .step_i   (step),
        .a_i      (a_i),
        .b_i      (b_i),
        .product_o(product_o)
    );

endmodule

// File: tb/tb_shift_add_mult_ctrl.sv
// Self-checking bench for shift_add_mult_ctrl at WIDTH = 8.
// Table of operand pairs with hand-computed products, plus directed
// sequences for ignored start, mid-operation reset and back-to-back starts.
module tb_shift_add_mult_ctrl;

    logic        clk;
    logic        reset;
    logic        startIn;
    logic [7:0]  aIn;
    logic [7:0]  bIn;
    logic        busyOut;
    logic        doneOut;
    logic [15:0] productOut;

    int checkCount = 0;
    int errorCount = 0;

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] expProduct;
    } vec_t;

    vec_t vecs[8];

    shift_add_mult_ctrl #(.WIDTH(8)) dut (
        .clk      (clk),
        .reset    (reset),
        .start_i  (startIn),
        .a_i      (aIn),
        .b_i      (bIn),
        .busy_o   (busyOut),
        .done_o   (doneOut),
        .product_o(productOut)
    );

    // 10 ns clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One comparison: count it, report a FAIL line on mismatch.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, actual, expected);
        end
    endtask

    // Issue one request and follow it for 10 edges, checking busy length,
    // done position, single done pulse, product at done and held product.
    task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b,
                                 input logic [15:0] expProduct, input string tag);
        int busyCycles = 0;
        int doneAt     = -1;
        int doneCnt    = 0;
        logic [15:0] doneProduct = '0;
        @(negedge clk);
        aIn     = a;
        bIn     = b;
        startIn = 1'b1;
        @(posedge clk);
        #1;
        startIn = 1'b0;
        if (busyOut) busyCycles++;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk);
            #1;
            if (busyOut) busyCycles++;
            if (doneOut) begin
                doneCnt++;
                if (doneAt < 0) begin
                    doneAt      = k;
                    doneProduct = productOut;
                end
            end
        end
        checkOutput({tag, " busyCycles"}, busyCycles, 8);
        checkOutput({tag, " doneAt"}, doneAt, 8);
        checkOutput({tag, " doneCount"}, doneCnt, 1);
        checkOutput({tag, " productAtDone"}, {16'h0, doneProduct}, {16'h0, expProduct});
        checkOutput({tag, " productHeld"}, {16'h0, productOut}, {16'h0, expProduct});
    endtask

    initial begin
        int busyCycles;
        int doneAt;
        int doneAt2;
        int doneCnt;
        logic [15:0] doneProduct;
        logic [15:0] doneProduct2;

        vecs[0] = '{8'd13,  8'd11,  16'h008F};
        vecs[1] = '{8'hFF,  8'hFF,  16'hFE01};
        vecs[2] = '{8'h00,  8'hA5,  16'h0000};
        vecs[3] = '{8'hA5,  8'h00,  16'h0000};
        vecs[4] = '{8'h01,  8'h01,  16'h0001};
        vecs[5] = '{8'h80,  8'h02,  16'h0100};
        vecs[6] = '{8'hFF,  8'h01,  16'h00FF};
        vecs[7] = '{8'd12,  8'd12,  16'd144};

        reset   = 1'b1;
        startIn = 1'b0;
        aIn     = '0;
        bIn     = '0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset busy", {31'h0, busyOut}, 0);
        checkOutput("reset done", {31'h0, doneOut}, 0);
        checkOutput("reset product", {16'h0, productOut}, 0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i].a, vecs[i].b, vecs[i].expProduct,
                          $sformatf("vec%0d", i));
        end

        // A second start mid-CALC (at E+3) must be ignored.
        busyCycles  = 0;
        doneAt      = -1;
        doneCnt     = 0;
        doneProduct = '0;
        @(negedge clk);
        aIn     = 8'd3;
        bIn     = 8'd5;
        startIn = 1'b1;
        @(posedge clk);
        #1;
        startIn = 1'b0;
        if (busyOut) busyCycles++;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            startIn = (k == 3);
            if (k == 3) begin
                aIn = 8'd7;
                bIn = 8'd7;
            end
            @(posedge clk);
            #1;
            if (busyOut) busyCycles++;
            if (doneOut) begin
                doneCnt++;
                if (doneAt < 0) begin
                    doneAt      = k;
                    doneProduct = productOut;
                end
            end
        end
        startIn = 1'b0;
        checkOutput("ignored busyCycles", busyCycles, 8);
        checkOutput("ignored doneAt", doneAt, 8);
        checkOutput("ignored doneCount", doneCnt, 1);
        checkOutput("ignored product", {16'h0, doneProduct}, 15);

        // Reset asserted shortly after E+4 aborts the operation.
        doneCnt = 0;
        @(negedge clk);
        aIn     = 8'd200;
        bIn     = 8'd100;
        startIn = 1'b1;
        @(posedge clk);
        #1;
        startIn = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk);
            #1;
            if (doneOut) doneCnt++;
        end
        checkOutput("abort busyBefore", {31'h0, busyOut}, 1);
        #1;
        reset = 1'b1;
        #1;
        checkOutput("abort busy", {31'h0, busyOut}, 0);
        checkOutput("abort done", {31'h0, doneOut}, 0);
        checkOutput("abort product", {16'h0, productOut}, 0);
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            #1;
            if (doneOut) doneCnt++;
        end
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            if (doneOut) doneCnt++;
        end
        checkOutput("abort doneCount", doneCnt, 0);
        applyStimulus(8'd2, 8'd3, 16'd6, "afterAbort");

        // Start held through DONE chains a second operation on the exit edge.
        doneAt       = -1;
        doneAt2      = -1;
        doneCnt      = 0;
        doneProduct  = '0;
        doneProduct2 = '0;
        busyCycles   = 0;
        @(negedge clk);
        aIn     = 8'd9;
        bIn     = 8'd9;
        startIn = 1'b1;
        @(posedge clk);
        #1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 9) begin
                aIn = 8'd4;
                bIn = 8'd5;
            end
            if (k >= 10) startIn = 1'b0;
            @(posedge clk);
            #1;
            if (k == 9 && busyOut) busyCycles++;
            if (doneOut) begin
                doneCnt++;
                if (doneAt < 0) begin
                    doneAt      = k;
                    doneProduct = productOut;
                end else if (doneAt2 < 0) begin
                    doneAt2      = k;
                    doneProduct2 = productOut;
                end
            end
        end
        startIn = 1'b0;
        checkOutput("chain firstDoneAt", doneAt, 8);
        checkOutput("chain firstProduct", {16'h0, doneProduct}, 81);
        checkOutput("chain busyAfterExit", busyCycles, 1);
        checkOutput("chain secondDoneAt", doneAt2, 17);
        checkOutput("chain secondProduct", {16'h0, doneProduct2}, 20);
        checkOutput("chain doneCount", doneCnt, 2);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
